scc_tone_generator_nch: RTL



---
 rtl/scc_tone_generator_nch.sv | 116 +++++++++++
 1 files changed

// File: rtl/scc_tone_generator_nch.sv
// Time-multiplexed wave-table tone generator: one shared update datapath serves
// CHANNELS channels. Each channel has its own period counter, read address and one-shot done flag.
module scc_tone_generator_nch #(
    parameter int CHANNELS = 5,
    parameter int SLOT_W   = 3,
    parameter int ADDR_W   = 5,
    parameter int FREQ_W   = 12,
    parameter int MIN_FREQ = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SLOT_W-1:0] active,
    input  logic              address_reset,
    input  logic              reg_enable,
    input  logic              reg_one_shot,
    input  logic [FREQ_W-1:0] reg_frequency_count,
    output logic [ADDR_W-1:0] wave_address,
    output logic [SLOT_W-1:0] out_channel,
    output logic              out_valid,
    output logic              end_pulse,
    output logic              done
);

    localparam int SLOT_W1 = SLOT_W + 1;
    localparam logic [FREQ_W-1:0] MIN_FREQ_C = FREQ_W'(MIN_FREQ);

    logic [FREQ_W-1:0]   cnt_r  [CHANNELS];
    logic [ADDR_W-1:0]   addr_r [CHANNELS];
    logic [CHANNELS-1:0] done_r;

    logic                valid_s;
    logic [FREQ_W-1:0]   cur_cnt_s;
    logic [ADDR_W-1:0]   cur_addr_s;
    logic                cur_done_s;
    logic [FREQ_W-1:0]   next_cnt_s;
    logic [ADDR_W-1:0]   next_addr_s;
    logic                next_done_s;
    logic                next_end_s;

    // Read mux: pick the stored state of the channel in the active slot.
    always_comb begin
        valid_s    = ({1'b0, active} < SLOT_W1'(CHANNELS));
        cur_cnt_s  = {FREQ_W{1'b0}};
        cur_addr_s = {ADDR_W{1'b0}};
        cur_done_s = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            cur_cnt_s  = cur_cnt_s  | ((active == SLOT_W'(i)) ? cnt_r[i]  : {FREQ_W{1'b0}});
            cur_addr_s = cur_addr_s | ((active == SLOT_W'(i)) ? addr_r[i] : {ADDR_W{1'b0}});
            cur_done_s = cur_done_s | ((active == SLOT_W'(i)) ? done_r[i] : 1'b0);
        end
    end

    // Shared update datapath; rules are prioritised top to bottom.
    always_comb begin
        next_cnt_s  = cur_cnt_s;
        next_addr_s = cur_addr_s;
        next_done_s = cur_done_s;
        next_end_s  = 1'b0;
        if (address_reset) begin
            next_cnt_s  = reg_frequency_count;
            next_addr_s = {ADDR_W{1'b0}};
            next_done_s = 1'b0;
        end else if (!reg_enable || cur_done_s || (reg_frequency_count < MIN_FREQ_C)) begin
            next_cnt_s  = cur_cnt_s;
        end else if ((cur_cnt_s == {FREQ_W{1'b0}}) && reg_one_shot &&
                     (cur_addr_s == {ADDR_W{1'b1}})) begin
            next_cnt_s  = reg_frequency_count;
            next_done_s = 1'b1;
            next_end_s  = 1'b1;
        end else if (cur_cnt_s == {FREQ_W{1'b0}}) begin
            next_cnt_s  = reg_frequency_count;
            next_addr_s = cur_addr_s + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            next_cnt_s  = cur_cnt_s - {{(FREQ_W-1){1'b0}}, 1'b1};
        end
    end

    // Per-channel storage write-back and registered, channel-tagged outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i]  <= {FREQ_W{1'b0}};
                addr_r[i] <= {ADDR_W{1'b0}};
            end
            done_r       <= {CHANNELS{1'b0}};
            wave_address <= {ADDR_W{1'b0}};
            out_channel  <= {SLOT_W{1'b0}};
            out_valid    <= 1'b0;
            end_pulse    <= 1'b0;
            done         <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (valid_s && (active == SLOT_W'(i))) begin
                    cnt_r[i]  <= next_cnt_s;
                    addr_r[i] <= next_addr_s;
                    done_r[i] <= next_done_s;
                end else begin
                    cnt_r[i]  <= cnt_r[i];
                    addr_r[i] <= addr_r[i];
                    done_r[i] <= done_r[i];
                end
            end
            if (valid_s) begin
                wave_address <= next_addr_s;
                out_channel  <= active;
                out_valid    <= 1'b1;
                end_pulse    <= next_end_s;
                done         <= next_done_s;
            end else begin
                out_valid    <= 1'b0;
                end_pulse    <= 1'b0;
            end
        end
    end

endmodule
